cpu_ctrl: RTL

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, REGREAD, ALU, optional MEM and
// WB, with a memory-wait watchdog, a halt state and a sticky fault state.
// All outputs are decoded from the registered state only (Moore).
module cpu_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_mem_ready,
  input  logic        I_memop,
  input  logic        I_shldBranch,
  input  logic        I_halt,
  output logic [5:0]  O_state,
  output logic        O_mem_req,
  output logic        O_alu_en,
  output logic        O_pc_load,
  output logic        O_pc_inc,
  output logic [15:0] O_instr_count,
  output logic        O_halted,
  output logic        O_fault
);

  // Wait counter is at least 4 bits, grows with MEM_TIMEOUT, capped at 16.
  localparam int CNT_W_RAW = (MEM_TIMEOUT < 16) ? 4 : $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W     = (CNT_W_RAW > 16) ? 16 : CNT_W_RAW;
  localparam int TO_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
  localparam bit TO_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_REGREAD, ST_ALU,
    ST_MEM, ST_WB, ST_HALT, ST_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic              br_q, br_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [15:0]       icnt_q, icnt_d;
  logic              timeout_hit;

  // Last permitted waiting cycle reached with memory still not ready.
  assign timeout_hit = TO_EN && (wait_q == TO_LAST) && !I_mem_ready;

  // State, branch, wait-counter and retire-counter registers.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      br_q    <= 1'b0;
      wait_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      wait_q  <= wait_d;
      icnt_q  <= icnt_d;
    end
  end

  // Next-state selection; a memory handshake beats the watchdog on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (I_mem_ready)      state_d = ST_DECODE;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = ST_REGREAD;
      ST_REGREAD: state_d = ST_ALU;
      ST_ALU:     state_d = I_memop ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (I_mem_ready)      state_d = ST_WB;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_WB:      state_d = I_halt ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = I_halt ? ST_HALT : ST_FETCH;
      ST_FAULT:   state_d = ST_FAULT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Branch capture on ALU exit, memory wait counting, retire counting on WB exit.
  always_comb begin
    br_d   = br_q;
    wait_d = wait_q;
    icnt_d = icnt_q;
    if (state_q == ST_ALU) br_d = I_shldBranch;
    if (((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q)) begin
      wait_d = '0;
    end else if ((state_q == ST_FETCH) || (state_q == ST_MEM)) begin
      if (I_mem_ready)      wait_d = '0;
      else if (wait_q != '1) wait_d = wait_q + 1'b1;
    end
    if (state_q == ST_WB) icnt_d = icnt_q + 16'd1;
  end

  // Moore output decode.
  always_comb begin
    O_state       = 6'b000000;
    O_mem_req     = 1'b0;
    O_alu_en      = 1'b0;
    O_pc_load     = 1'b0;
    O_pc_inc      = 1'b0;
    O_halted      = 1'b0;
    O_fault       = 1'b0;
    O_instr_count = icnt_q;
    case (state_q)
      ST_FETCH:   begin O_state = 6'b000001; O_mem_req = 1'b1; end
      ST_DECODE:  O_state = 6'b000010;
      ST_REGREAD: O_state = 6'b000100;
      ST_ALU:     begin O_state = 6'b001000; O_alu_en = 1'b1; end
      ST_MEM:     begin O_state = 6'b010000; O_mem_req = 1'b1; end
      ST_WB: begin
        O_state   = 6'b100000;
        O_pc_load = br_q;
        O_pc_inc  = ~br_q;
      end
      ST_HALT:    O_halted = 1'b1;
      ST_FAULT:   O_fault = 1'b1;
      default:    O_state = 6'b000000;
    endcase
  end

endmodule
